microcode_unit: RTL and testbench
=================================

# microcode_unit

Single-issue microcode sequencer. It owns a micro-program counter and drives it out as `uop_addr` to an external uop store (ROM/RAM). It executes the 32-bit uop returned combinationally on `uop`, one uop per clock, against an internal 16×32 register file. A 4-deep return stack supports micro-subroutines. It sits between the uop store and the rest of the core; in the current integration it is observed only through `uop_addr` and hierarchical probes.

## Interface
- `UOP_BUF_SIZE`, default 128: number of uop store entries. Must be a power of two, ≥ 2.
- `UOP_BUF_WIDTH`, default 32: uop width. The encoding below requires exactly 32.
- `ADDR_W` (localparam) = `$clog2(UOP_BUF_SIZE)`, 7 by default.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `uop_addr`  out  ADDR_W  registered micro-PC (upc); address presented to the uop store.
- `uop`  in  UOP_BUF_WIDTH  uop at `uop_addr`, valid combinationally in the same cycle.

## Operation
- Uop fields:
  - `[31:28]` op
  - `[27:24]` rd
  - `[23:20]` rs
  - `[19:16]` rt
  - `[15:0]` imm
  - `tgt` = imm[ADDR_W-1:0]
  - `simm` = imm sign-extended to 32 bits
- r0 reads as 0; writes to r0 are discarded.
- Opcodes (next upc is upc+1 unless stated):
  - 0 NOP: no state change.
  - 1 LDI: rd ← simm.
  - 2 ADD: rd ← rs+rt. 3 SUB: rd ← rs−rt. 4 AND. 5 OR. 6 XOR.
  - 7 ADDI: rd ← rs+simm.
  - 8 JMP: upc ← tgt.
  - 9 BEQZ: if rs==0 then upc ← tgt.
  - A BNEZ: if rs!=0 then upc ← tgt.
  - B CALL: push upc+1, then upc ← tgt.
  - C RET: pop into upc.
  - D HALT: set `halted`; upc and all state frozen.
  - E–F: NOP.
- Arithmetic is 32-bit modulo 2^32. No flags, no traps.
- upc+1 wraps from UOP_BUF_SIZE−1 to 0. Pushed return addresses wrap the same way.
- Return stack: 4 entries, ADDR_W bits each, with a 3-bit `sp` (0..4).
  - CALL with sp==4: no push (discarded), jump still taken.
  - RET with sp==0: acts as NOP (upc+1).
- Register reads see pre-edge values. A uop may read and write the same register, e.g. ADDI r1,r1,1.
- `halted` is cleared only by reset.
- `uop` value X/undefined while halted has no effect.

## Timing
- Reset asserted (reset==0), asynchronously:
  - upc=0, so `uop_addr`=0
  - all registers 0
  - sp=0, stack entries 0
  - halted=0
- Reset is honored at any time, including mid-subroutine or while halted. The first uop after deassertion executes from address 0.
- First executing edge: the first rising `clk` with reset==1 executes uop[0].
- Latency: each uop completes on the edge that ends its fetch cycle; the result is visible the next cycle. A taken branch, JMP, CALL or RET has zero bubble: the new `uop_addr` appears right after that edge.
- Throughput: 1 uop/cycle; no stalls.

## Structure
- Package `microcode_pkg`:
  - `op_e` enum (NOP…HALT, 4 bits)
  - field position constants
  - `STACK_DEPTH`=4
  - `NUM_REGS`=16
- One natural sub-module: `microcode_alu`, a combinational 32-bit op on (op, a, b) → result covering ADD/SUB/AND/OR/XOR/ADDI/LDI.
- Sequencer, register file and stack stay in `microcode_unit`.
- Internal names `regs[0:15]`, `sp` and `halted` are stable for hierarchical probing by benches.

## Test plan
- Reset then NOP stream → `uop_addr` goes 0,1,2,…,127,0: wraps at 128, all regs stay 0.
- LDI r1,5; LDI r2,−3; ADD r3,r1,r2; SUB r4,r2,r1; XOR r5,r1,r1 → r3=2, r4=0xFFFFFFF8, r5=0. LDI r0,7 leaves r0=0.
- LDI r1,3; loop: ADDI r1,r1,−1; BNEZ r1,loop; HALT → BNEZ taken twice, then falls through. r1=0, `uop_addr` frozen at the HALT address.
- CALL 0x40 at address 2, RET at 0x40 → `uop_addr` sequence 2,0x40,3. Five nested CALLs leave sp=4. The fifth return is lost, and RET with sp==0 advances by 1.
- JMP 0x7F, then NOP at 0x7F → next `uop_addr`=0.
- Reset pulsed low asynchronously, mid-clock while halted inside a subroutine → `uop_addr`=0 immediately. sp=0, halted=0, regs=0, and execution restarts from 0.

Source files
------------

// File: rtl/microcode_pkg.sv
// Shared definitions for the microcode sequencer: opcode encoding, uop field
// positions and the sizes of the register file and return stack.
package microcode_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LDI   = 4'h1,
    OP_ADD   = 4'h2,
    OP_SUB   = 4'h3,
    OP_AND   = 4'h4,
    OP_OR    = 4'h5,
    OP_XOR   = 4'h6,
    OP_ADDI  = 4'h7,
    OP_JMP   = 4'h8,
    OP_BEQZ  = 4'h9,
    OP_BNEZ  = 4'hA,
    OP_CALL  = 4'hB,
    OP_RET   = 4'hC,
    OP_HALT  = 4'hD,
    OP_RSV_E = 4'hE,
    OP_RSV_F = 4'hF
  } op_e;

  localparam int OP_LSB  = 28;
  localparam int RD_LSB  = 24;
  localparam int RS_LSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 16;

  localparam int NUM_REGS    = 16;
  localparam int STACK_DEPTH = 4;
  localparam int SP_W        = 3;
  localparam int SIDX_W      = 2;

endpackage

// File: rtl/microcode_alu.sv
// Combinational 32-bit datapath for the register-writing uops. LDI passes the
// sign-extended immediate through on b_i; ADDI shares the adder with ADD.
module microcode_alu
  import microcode_pkg::*;
(
  input  op_e         op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_LDI:           result_o = b_i;
      OP_ADD, OP_ADDI:  result_o = a_i + b_i;
      OP_SUB:           result_o = a_i - b_i;
      OP_AND:           result_o = a_i & b_i;
      OP_OR:            result_o = a_i | b_i;
      OP_XOR:           result_o = a_i ^ b_i;
      default:          result_o = '0;
    endcase
  end

endmodule

// File: rtl/microcode_unit.sv
// Single-issue microcode sequencer: one uop per clock from an external store,
// 16x32 register file, 4-entry return stack, sticky halt cleared by reset.
module microcode_unit
  import microcode_pkg::*;
#(
  parameter  int UOP_BUF_SIZE  = 128,
  parameter  int UOP_BUF_WIDTH = 32,
  localparam int ADDR_W        = $clog2(UOP_BUF_SIZE)
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [ADDR_W-1:0]        uop_addr,
  input  logic [UOP_BUF_WIDTH-1:0] uop
);

  logic [ADDR_W-1:0] upc_q, upc_d;
  logic [31:0]       regs    [0:NUM_REGS-1];
  logic [ADDR_W-1:0] stack_q [0:STACK_DEPTH-1];
  logic [SP_W-1:0]   sp, sp_d, sp_m1;
  logic              halted, halted_d;

  op_e               op;
  logic [3:0]        rd_idx, rs_idx, rt_idx;
  logic [IMM_W-1:0]  imm;
  logic [31:0]       simm, rs_val, rt_val, alu_b, alu_res;
  logic [ADDR_W-1:0] tgt, upc_inc;
  logic              wr_en, push_en;

  assign op      = op_e'(uop[OP_LSB +: 4]);
  assign rd_idx  = uop[RD_LSB +: 4];
  assign rs_idx  = uop[RS_LSB +: 4];
  assign rt_idx  = uop[RT_LSB +: 4];
  assign imm     = uop[IMM_LSB +: IMM_W];
  assign simm    = {{(32-IMM_W){imm[IMM_W-1]}}, imm};
  assign tgt     = imm[ADDR_W-1:0];
  assign upc_inc = upc_q + ADDR_W'(1);
  assign sp_m1   = sp - SP_W'(1);

  assign rs_val  = (rs_idx == 4'd0) ? 32'd0 : regs[rs_idx];
  assign rt_val  = (rt_idx == 4'd0) ? 32'd0 : regs[rt_idx];
  assign alu_b   = (op == OP_LDI || op == OP_ADDI) ? simm : rt_val;

  microcode_alu u_alu (
    .op_i     (op),
    .a_i      (rs_val),
    .b_i      (alu_b),
    .result_o (alu_res)
  );

  always_comb begin
    upc_d    = upc_inc;
    sp_d     = sp;
    halted_d = halted;
    wr_en    = 1'b0;
    push_en  = 1'b0;
    case (op)
      OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: wr_en = 1'b1;
      OP_JMP:  upc_d = tgt;
      OP_BEQZ: if (rs_val == 32'd0) upc_d = tgt;
      OP_BNEZ: if (rs_val != 32'd0) upc_d = tgt;
      OP_CALL: begin
        // A full stack drops the return address but the jump still happens.
        upc_d = tgt;
        if (sp != SP_W'(STACK_DEPTH)) begin
          push_en = 1'b1;
          sp_d    = sp + SP_W'(1);
        end
      end
      OP_RET: begin
        if (sp != '0) begin
          upc_d = stack_q[sp_m1[SIDX_W-1:0]];
          sp_d  = sp_m1;
        end
      end
      OP_HALT: begin
        upc_d    = upc_q;
        halted_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upc_q  <= '0;
      sp     <= '0;
      halted <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else if (!halted) begin
      upc_q  <= upc_d;
      sp     <= sp_d;
      halted <= halted_d;
      if (wr_en && rd_idx != 4'd0) regs[rd_idx] <= alu_res;
      if (push_en) stack_q[sp[SIDX_W-1:0]] <= upc_inc;
    end
  end

  assign uop_addr = upc_q;

endmodule

// File: tb/tb_microcode_unit.sv
// Bench for microcode_unit: a uop ROM model drives the DUT; the expected
// uop_addr trace is queued per program and compared one entry per cycle.
module tb_microcode_unit;
  import microcode_pkg::*;

  localparam int AW = 7;

  logic          clk;
  logic          reset;
  logic [AW-1:0] uop_addr;
  logic [31:0]   uop;
  logic [31:0]   rom [0:127];

  logic [31:0]   exp_q[$];
  int            n_tests;
  int            n_fail;

  microcode_unit #(.UOP_BUF_SIZE(128), .UOP_BUF_WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .uop_addr (uop_addr),
    .uop      (uop)
  );

  assign uop = rom[uop_addr];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs, input logic [3:0] rt,
                                     input logic [15:0] imm);
    return {op, rd, rs, rt, imm};
  endfunction

  function automatic logic [31:0] sext(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) rom[i] = 32'h0;
  endtask

  // Enter reset (ROM may then be loaded while reset is held).
  task automatic enter_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    exp_q.delete();
    clear_rom();
  endtask

  task automatic release_reset(input string tag);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++) acc = acc | dut.regs[i];
    check({tag, "_rst_addr"}, 32'(uop_addr), 32'd0);
    check({tag, "_rst_sp"}, 32'(dut.sp), 32'd0);
    check({tag, "_rst_halt"}, 32'(dut.halted), 32'd0);
    check({tag, "_rst_regs"}, acc, 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Scoreboard drain: compare uop_addr against the queue once per cycle.
  task automatic run_expect(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) begin
        check({tag, "_queue_empty"}, 32'd1, 32'd0);
      end else begin
        check(tag, 32'(uop_addr), exp_q.pop_front());
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [15:0] a, b;
    logic [31:0] acc;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    clear_rom();

    // NOP stream: full wrap of the micro-PC, registers untouched.
    enter_reset();
    release_reset("nop");
    for (int i = 0; i < 130; i++) exp_q.push_back(32'(i % 128));
    run_expect("nop_addr", 130);
    acc = '0;
    for (int i = 0; i < 16; i++) acc = acc | dut.regs[i];
    check("nop_regs", acc, 32'd0);

    // Directed ALU program.
    enter_reset();
    rom[0] = mk(OP_LDI, 1, 0, 0, 16'd5);
    rom[1] = mk(OP_LDI, 2, 0, 0, 16'hFFFD);
    rom[2] = mk(OP_ADD, 3, 1, 2, 16'd0);
    rom[3] = mk(OP_SUB, 4, 2, 1, 16'd0);
    rom[4] = mk(OP_XOR, 5, 1, 1, 16'd0);
    rom[5] = mk(OP_LDI, 0, 0, 0, 16'd7);
    rom[6] = mk(OP_AND, 6, 1, 2, 16'd0);
    rom[7] = mk(OP_OR,  7, 1, 2, 16'd0);
    rom[8] = mk(OP_ADDI, 8, 2, 0, 16'h7FFF);
    rom[9] = mk(OP_HALT, 0, 0, 0, 16'd0);
    release_reset("alu");
    for (int i = 0; i < 12; i++) exp_q.push_back(32'(i < 9 ? i : 9));
    run_expect("alu_addr", 12);
    check("alu_r3", dut.regs[3], 32'd2);
    check("alu_r4", dut.regs[4], 32'hFFFF_FFF8);
    check("alu_r5", dut.regs[5], 32'd0);
    check("alu_r0", dut.regs[0], 32'd0);
    check("alu_r6", dut.regs[6], 32'd5);
    check("alu_r7", dut.regs[7], 32'hFFFF_FFFD);
    check("alu_r8", dut.regs[8], 32'h0000_7FFC);
    check("alu_halt", 32'(dut.halted), 32'd1);

    // Random operands through every ALU op.
    for (int t = 0; t < 4; t++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(0, 65535));
      enter_reset();
      rom[0] = mk(OP_LDI, 1, 0, 0, a);
      rom[1] = mk(OP_LDI, 2, 0, 0, b);
      rom[2] = mk(OP_ADD, 3, 1, 2, 16'd0);
      rom[3] = mk(OP_SUB, 4, 1, 2, 16'd0);
      rom[4] = mk(OP_AND, 5, 1, 2, 16'd0);
      rom[5] = mk(OP_OR,  6, 1, 2, 16'd0);
      rom[6] = mk(OP_XOR, 7, 1, 2, 16'd0);
      rom[7] = mk(OP_ADDI, 8, 1, 0, b);
      rom[8] = mk(OP_HALT, 0, 0, 0, 16'd0);
      release_reset("rnd");
      for (int i = 0; i < 10; i++) exp_q.push_back(32'(i < 8 ? i : 8));
      run_expect("rnd_addr", 10);
      check("rnd_add",  dut.regs[3], sext(a) + sext(b));
      check("rnd_sub",  dut.regs[4], sext(a) - sext(b));
      check("rnd_and",  dut.regs[5], sext(a) & sext(b));
      check("rnd_or",   dut.regs[6], sext(a) | sext(b));
      check("rnd_xor",  dut.regs[7], sext(a) ^ sext(b));
      check("rnd_addi", dut.regs[8], sext(a) + sext(b));
    end

    // Countdown loop with BNEZ, then BEQZ taken / BNEZ not taken.
    enter_reset();
    rom[0] = mk(OP_LDI,  1, 0, 0, 16'd3);
    rom[1] = mk(OP_ADDI, 1, 1, 0, 16'hFFFF);
    rom[2] = mk(OP_BNEZ, 0, 1, 0, 16'd1);
    rom[3] = mk(OP_BEQZ, 0, 1, 0, 16'd5);
    rom[4] = mk(OP_HALT, 0, 0, 0, 16'd0);
    rom[5] = mk(OP_BNEZ, 0, 1, 0, 16'd0);
    rom[6] = mk(OP_HALT, 0, 0, 0, 16'd0);
    release_reset("loop");
    foreach (rom[k]) if (k < 0) exp_q.push_back(32'd0);
    exp_q = '{32'd0, 32'd1, 32'd2, 32'd1, 32'd2, 32'd1, 32'd2, 32'd3, 32'd5, 32'd6, 32'd6, 32'd6};
    run_expect("loop_addr", 12);
    check("loop_r1", dut.regs[1], 32'd0);
    check("loop_halt", 32'(dut.halted), 32'd1);

    // Simple CALL/RET.
    enter_reset();
    rom[2]    = mk(OP_CALL, 0, 0, 0, 16'h0040);
    rom[3]    = mk(OP_HALT, 0, 0, 0, 16'd0);
    rom[7'h40] = mk(OP_RET, 0, 0, 0, 16'd0);
    release_reset("call");
    exp_q = '{32'd0, 32'd1, 32'd2, 32'h40, 32'd3, 32'd3};
    run_expect("call_addr", 6);
    check("call_sp", 32'(dut.sp), 32'd0);

    // Five nested CALLs: the fifth return is lost; RET on empty stack steps by 1.
    enter_reset();
    rom[7'h00] = mk(OP_CALL, 0, 0, 0, 16'h0010);
    rom[7'h10] = mk(OP_CALL, 0, 0, 0, 16'h0020);
    rom[7'h20] = mk(OP_CALL, 0, 0, 0, 16'h0030);
    rom[7'h30] = mk(OP_CALL, 0, 0, 0, 16'h0040);
    rom[7'h40] = mk(OP_CALL, 0, 0, 0, 16'h0050);
    rom[7'h50] = mk(OP_RET,  0, 0, 0, 16'd0);
    rom[7'h31] = mk(OP_RET,  0, 0, 0, 16'd0);
    rom[7'h21] = mk(OP_RET,  0, 0, 0, 16'd0);
    rom[7'h11] = mk(OP_RET,  0, 0, 0, 16'd0);
    rom[7'h01] = mk(OP_RET,  0, 0, 0, 16'd0);
    rom[7'h02] = mk(OP_HALT, 0, 0, 0, 16'd0);
    release_reset("nest");
    exp_q = '{32'h00, 32'h10, 32'h20, 32'h30, 32'h40, 32'h50, 32'h31,
              32'h21, 32'h11, 32'h01, 32'h02, 32'h02};
    run_expect("nest_addr", 5);
    check("nest_sp_full", 32'(dut.sp), 32'd4);
    run_expect("nest_addr", 7);
    check("nest_sp_end", 32'(dut.sp), 32'd0);

    // Pushed return address and micro-PC wrap at the top of the store, plus JMP.
    enter_reset();
    rom[7'h00] = mk(OP_BEQZ, 0, 2, 0, 16'h007E);
    rom[7'h7F] = mk(OP_CALL, 0, 0, 0, 16'h0030);
    rom[7'h30] = mk(OP_ADDI, 2, 2, 0, 16'd1);
    rom[7'h31] = mk(OP_RET,  0, 0, 0, 16'd0);
    rom[7'h01] = mk(OP_JMP,  0, 0, 0, 16'h0005);
    rom[7'h05] = mk(OP_HALT, 0, 0, 0, 16'd0);
    release_reset("wrap");
    exp_q = '{32'h00, 32'h7E, 32'h7F, 32'h30, 32'h31, 32'h00, 32'h01, 32'h05, 32'h05};
    run_expect("wrap_addr", 9);
    check("wrap_r2", dut.regs[2], 32'd1);

    // Asynchronous reset mid-cycle while halted inside a subroutine.
    enter_reset();
    rom[7'h00] = mk(OP_CALL, 0, 0, 0, 16'h0040);
    rom[7'h40] = mk(OP_LDI,  3, 0, 0, 16'd9);
    rom[7'h41] = mk(OP_HALT, 0, 0, 0, 16'd0);
    release_reset("arst");
    exp_q = '{32'h00, 32'h40, 32'h41, 32'h41, 32'h41};
    run_expect("arst_addr", 5);
    check("arst_pre_sp", 32'(dut.sp), 32'd1);
    check("arst_pre_halt", 32'(dut.halted), 32'd1);
    check("arst_pre_r3", dut.regs[3], 32'd9);
    #2;
    reset = 1'b0;
    #1;
    check("arst_addr_now", 32'(uop_addr), 32'd0);
    check("arst_sp_now", 32'(dut.sp), 32'd0);
    check("arst_halt_now", 32'(dut.halted), 32'd0);
    check("arst_r3_now", dut.regs[3], 32'd0);
    #1;
    reset = 1'b1;
    exp_q = '{32'h40, 32'h41, 32'h41};
    @(negedge clk);
    run_expect("arst_restart", 3);
    check("arst_post_r3", dut.regs[3], 32'd9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
